// File: rtl/klingon_display_scan_if.sv
// Bundles the digit-load inputs and scan outputs of klingon_display_scan.
// The master side feeds digits and LOAD; the slave side is the scanner.
interface klingon_display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] DIGITS;
  logic [NUM_DIGITS-1:0]   DIGIT_EN;
  logic                    LOAD;
  logic [3:0]              NUM;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    BLANK;
  logic                    FRAME_DONE;

  modport master (
    output DIGITS, DIGIT_EN, LOAD,
    input  NUM, AN, BLANK, FRAME_DONE
  );

  modport slave (
    input  DIGITS, DIGIT_EN, LOAD,
    output NUM, AN, BLANK, FRAME_DONE
  );
endinterface

// File: rtl/klingon_display_scan.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Each digit slot begins with a blanking interval so the decoder settles first.
module klingon_display_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic                   CLK,
  input logic                   RST,
  klingon_display_scan_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIG_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_p0, cnt_n;
  logic [IDX_W-1:0]      idx_p0, idx_n;
  logic [DIG_W-1:0]      shadow_dig_p0, act_dig_p0, act_dig_n;
  logic [NUM_DIGITS-1:0] shadow_en_p0, act_en_p0, act_en_n;
  logic                  pending_p0;
  logic                  wrap, boundary;
  logic [3:0]            num_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  frame_done_n;

  // Stage p0 next-state: outputs are computed from the state the registers
  // are about to take, so every output is a flop yet tracks the counters.
  always_comb begin
    wrap     = (cnt_p0 == CNT_LAST);
    boundary = wrap && (idx_p0 == IDX_LAST);
    cnt_n    = wrap ? '0 : cnt_p0 + CNT_W'(1);
    idx_n    = idx_p0;
    if (wrap) begin
      idx_n = (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
    end

    // A LOAD landing exactly on the frame boundary bypasses the shadow copy.
    act_dig_n = act_dig_p0;
    act_en_n  = act_en_p0;
    if (boundary) begin
      if (bus.LOAD) begin
        act_dig_n = bus.DIGITS;
        act_en_n  = bus.DIGIT_EN;
      end else if (pending_p0) begin
        act_dig_n = shadow_dig_p0;
        act_en_n  = shadow_en_p0;
      end
    end

    num_n = '0;
    an_n  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_n == IDX_W'(i)) begin
        num_n = act_dig_n[4*i +: 4];
        if ((cnt_n >= CNT_BLANK) && act_en_n[i]) an_n[i] = 1'b0;
      end
    end
    frame_done_n = (idx_n == IDX_LAST) && (cnt_n == CNT_LAST);
  end

  // Stage p1: registered state and outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0         <= '0;
      idx_p0         <= '0;
      shadow_dig_p0  <= '0;
      shadow_en_p0   <= '0;
      act_dig_p0     <= '0;
      act_en_p0      <= '0;
      pending_p0     <= 1'b0;
      bus.NUM        <= '0;
      bus.AN         <= '1;
      bus.BLANK      <= 1'b1;
      bus.FRAME_DONE <= 1'b0;
    end else begin
      cnt_p0     <= cnt_n;
      idx_p0     <= idx_n;
      act_dig_p0 <= act_dig_n;
      act_en_p0  <= act_en_n;
      if (bus.LOAD) begin
        shadow_dig_p0 <= bus.DIGITS;
        shadow_en_p0  <= bus.DIGIT_EN;
      end
      pending_p0     <= boundary ? 1'b0 : (pending_p0 | bus.LOAD);
      bus.NUM        <= num_n;
      bus.AN         <= an_n;
      bus.BLANK      <= &an_n;
      bus.FRAME_DONE <= frame_done_n;
    end
  end
endmodule

// File: tb/tb_klingon_display_scan.sv
// Bench for klingon_display_scan with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2,
// compared cycle by cycle against a cycle-count-based reference model.
module tb_klingon_display_scan;
  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * RD;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  klingon_display_scan_if #(.NUM_DIGITS(ND)) bus ();

  klingon_display_scan #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since reset release plus displayed/shadow data.
  int          m_t;
  logic [15:0] m_act_d, m_sh_d;
  logic [3:0]  m_act_e, m_sh_e;
  logic        m_pend;
  logic [9:0]  exp_vec;
  wire  [9:0]  obs = {bus.NUM, bus.AN, bus.BLANK, bus.FRAME_DONE};

  task automatic model_outputs();
    int idx, c;
    logic [3:0] num, an;
    idx = (m_t / RD) % ND;
    c   = m_t % RD;
    num = m_act_d[idx*4 +: 4];
    an  = 4'hF;
    if (c >= BC && m_act_e[idx]) an[idx] = 1'b0;
    exp_vec = {num, an, (an == 4'hF), (idx == ND-1 && c == RD-1)};
  endtask

  // Drives one cycle of inputs, advances model across the edge, lands at negedge.
  task automatic run_cycle(input logic ld, input logic [15:0] d,
                           input logic [3:0] e, input logic r);
    bus.LOAD = ld; bus.DIGITS = d; bus.DIGIT_EN = e; RST = r;
    @(posedge CLK);
    if (r) begin
      m_t = 0; m_act_d = '0; m_act_e = '0; m_sh_d = '0; m_sh_e = '0; m_pend = 1'b0;
    end else begin
      if (ld) begin m_sh_d = d; m_sh_e = e; m_pend = 1'b1; end
      if ((m_t % FRAME) == FRAME-1 && m_pend) begin
        m_act_d = m_sh_d; m_act_e = m_sh_e; m_pend = 1'b0;
      end
      m_t++;
    end
    @(negedge CLK);
    bus.LOAD = 1'b0;
    model_outputs();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 16'hFFFF, 4'hF, 1'b1);
    n_tests++;
    if (obs !== 10'b0000_1111_1_0) begin
      n_fail++; $display("FAIL reset_values: got %b expected %b", obs, 10'b0000_1111_1_0);
    end
    n_tests++;
    if (obs !== exp_vec) begin
      n_fail++; $display("FAIL reset_model: got %b expected %b", obs, exp_vec);
    end
  endtask

  task automatic test_idle_no_load();
    int first_fd = -1;
    run_cycle(1'b0, 16'h0, 4'h0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      run_cycle(1'b0, 16'($urandom), 4'($urandom), 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL idle cycle %0d: got %b expected %b", c+1, obs, exp_vec);
      end
      if (bus.FRAME_DONE && first_fd < 0) first_fd = c + 1;
    end
    n_tests++;
    if (first_fd !== 31) begin
      n_fail++; $display("FAIL idle_first_frame_done: got %0d expected 31", first_fd);
    end
  endtask

  task automatic test_load_mid_frame();
    run_cycle(1'b0, 16'h0, 4'h0, 1'b1);
    for (int c = 0; c < 64; c++) begin
      run_cycle(c == 3, 16'h3A51, 4'hF, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL load_mid cycle %0d: got %b expected %b", c+1, obs, exp_vec);
      end
      if (c + 1 == 43) begin
        n_tests++;
        if ({bus.NUM, bus.AN} !== {4'h5, 4'b1101}) begin
          n_fail++; $display("FAIL load_mid_digit1: got %h/%b expected 5/1101", bus.NUM, bus.AN);
        end
      end
    end
  endtask

  task automatic test_load_on_frame_done();
    run_cycle(1'b0, 16'h0, 4'h0, 1'b1);
    for (int c = 0; c < 64; c++) begin
      run_cycle(c == 31, 16'h0007, 4'b0001, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL load_fd cycle %0d: got %b expected %b", c+1, obs, exp_vec);
      end
      if (c + 1 == 35) begin
        n_tests++;
        if ({bus.NUM, bus.AN} !== {4'h7, 4'b1110}) begin
          n_fail++; $display("FAIL load_fd_applied: got %h/%b expected 7/1110", bus.NUM, bus.AN);
        end
      end
    end
  endtask

  task automatic test_back_to_back_loads();
    run_cycle(1'b0, 16'h0, 4'h0, 1'b1);
    for (int c = 0; c < 96; c++) begin
      run_cycle(c == 40 || c == 50, (c == 40) ? 16'h1111 : 16'h2222, 4'hF, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL b2b cycle %0d: got %b expected %b", c+1, obs, exp_vec);
      end
      if (c + 1 >= 64 && bus.NUM !== 4'h2) begin
        n_tests++; n_fail++;
        $display("FAIL b2b_last_wins cycle %0d: got %h expected 2", c+1, bus.NUM);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    run_cycle(1'b0, 16'h0, 4'h0, 1'b1);
    for (int c = 0; c < 80; c++) begin
      run_cycle(c == 3, 16'h3A51, 4'hF, c == 45);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL rst_mid cycle %0d: got %b expected %b", c+1, obs, exp_vec);
      end
      if (c + 1 == 46) begin
        n_tests++;
        if ({bus.NUM, bus.AN, bus.FRAME_DONE} !== {4'h0, 4'hF, 1'b0}) begin
          n_fail++; $display("FAIL rst_mid_values: got %h/%b expected 0/1111", bus.NUM, bus.AN);
        end
      end
    end
  endtask

  task automatic test_random_loads();
    int last_fd = -1;
    run_cycle(1'b0, 16'h0, 4'h0, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      run_cycle($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++; $display("FAIL random cycle %0d: got %b expected %b", c+1, obs, exp_vec);
      end
      n_tests++;
      if ($countones(~bus.AN) > 1 || bus.BLANK !== (bus.AN == 4'hF)) begin
        n_fail++; $display("FAIL random_anode cycle %0d: AN=%b BLANK=%b", c+1, bus.AN, bus.BLANK);
      end
      if (bus.FRAME_DONE) begin
        if (last_fd >= 0) begin
          n_tests++;
          if (c - last_fd !== FRAME) begin
            n_fail++; $display("FAIL random_fd_period: got %0d expected %0d", c - last_fd, FRAME);
          end
        end
        last_fd = c;
      end
    end
  endtask

  initial begin
    bus.LOAD = 1'b0; bus.DIGITS = '0; bus.DIGIT_EN = '0;
    m_t = 0; m_act_d = '0; m_act_e = '0; m_sh_d = '0; m_sh_e = '0; m_pend = 1'b0;
    exp_vec = '0;
    test_reset();
    test_idle_no_load();
    test_load_mid_frame();
    test_load_on_frame_done();
    test_back_to_back_loads();
    test_reset_mid_scan();
    test_random_loads();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
